matrix_gen_3x3: RTL

- Streaming 3x3 window generator; the producer side of the matrix interface that the threshold, NMS and Sobel stages consume.
- Takes a raster pixel stream (start / data_en / pixel).
- Buffers two previous lines and emits p11..p33 with matrix_clken and data_valid (1 = window invalid).
- Sits between the padding/previous stage and any 3x3 consumer.

---
 rtl/matrix_gen_3x3.sv | 115 +++++++++++
 1 files changed

// File: rtl/matrix_gen_3x3.sv
// Streaming 3x3 window generator: two circular line buffers plus a 3x3 shift
// window, emitting p11..p33 one cycle after each accepted raster pixel.
module matrix_gen_3x3 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned DEPTH      = 504
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  matrix_clken,
    output logic                  data_valid,
    output logic                  start_sync
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DEPTH - 1);

    logic                  acc;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] lb1 [WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [WIDTH];
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] lb2_rd;
    logic                  border;

    assign acc    = start && data_en;
    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];
    assign border = (row < ROW_W'(2)) || (col < COL_W'(2));

    // Raster position of the pixel being accepted; wraps at frame end so
    // consecutive frames need no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!start) begin
            col <= '0;
            row <= '0;
        end else if (data_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Line buffers: read old contents, then shift row r-1 into r-2 and store
    // the new pixel as row r-1 for the next line.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[col] <= lb1_rd;
            lb1[col] <= pixel;
        end
    end

    // Window shifts left by one column per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_p11 <= '0;
            matrix_p12 <= '0;
            matrix_p13 <= '0;
            matrix_p21 <= '0;
            matrix_p22 <= '0;
            matrix_p23 <= '0;
            matrix_p31 <= '0;
            matrix_p32 <= '0;
            matrix_p33 <= '0;
        end else if (acc) begin
            matrix_p11 <= matrix_p12;
            matrix_p12 <= matrix_p13;
            matrix_p13 <= lb2_rd;
            matrix_p21 <= matrix_p22;
            matrix_p22 <= matrix_p23;
            matrix_p23 <= lb1_rd;
            matrix_p31 <= matrix_p32;
            matrix_p32 <= matrix_p33;
            matrix_p33 <= pixel;
        end
    end

    // Strobe and validity flag; validity holds between accepted pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_clken <= 1'b0;
            data_valid   <= 1'b0;
            start_sync   <= 1'b0;
        end else begin
            matrix_clken <= acc;
            start_sync   <= start;
            if (acc) begin
                data_valid <= border;
            end
        end
    end

endmodule
